gate_exhaustive_checker: RTL

Self-checking stimulus/response engine for the gate library. On `start`, it drives every input combination (0 to 2^N_IN−1) into a combinational gate DUT and waits a settle interval after each vector. It then compares the DUT output against a built-in golden model for the selected gate function, and reports an error count, the first failing vector and a pass flag. It sits directly upstream of the gate under test (drives its inputs) and consumes its output, replacing hand-written `$monitor` benches with a synthesizable, cycle-exact checker.

---
 rtl/gate_exhaustive_checker_if.sv | 28 ++
 rtl/gate_exhaustive_checker.sv | 121 ++++++++++++
 2 files changed

// File: rtl/gate_exhaustive_checker_if.sv
// Handshake bundle between the exhaustive checker and its driver.
// Carries run control, stimulus to the gate and captured results.
interface gate_exhaustive_checker_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [2:0]      op;
    logic [N_IN-1:0] stim;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, op, dut_y,
        input  stim, busy, done, pass,
        input  err_count, fail_valid, first_fail
    );

    modport slave (
        input  start, op, dut_y,
        output stim, busy, done, pass,
        output err_count, fail_valid, first_fail
    );
endinterface

// File: rtl/gate_exhaustive_checker.sv
// Exhaustive stimulus/response checker for a combinational gate.
// Sweeps all input vectors, compares against a golden op, logs errors.
module gate_exhaustive_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    gate_exhaustive_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic [2:0]      op_r;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail;

    logic            exp_y;
    logic            mismatch;
    logic [N_IN:0]   err_nxt;

    assign bus.stim       = stim;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_count  = err_count;
    assign bus.fail_valid = fail_valid;
    assign bus.first_fail = first_fail;

    // Golden response for the latched function on the current vector.
    always_comb begin
        exp_y = 1'b0;
        unique case (op_r)
            3'd0: exp_y = &stim;
            3'd1: exp_y = |stim;
            3'd2: exp_y = ~&stim;
            3'd3: exp_y = ~|stim;
            3'd4: exp_y = ^stim;
            3'd5: exp_y = ~^stim;
            3'd6: exp_y = stim[0];
            3'd7: exp_y = ~stim[0];
        endcase
    end

    assign mismatch = (bus.dut_y != exp_y);
    assign err_nxt  = err_count + {{N_IN{1'b0}}, mismatch};

    // Run sequencer: settle, sample, advance; results held in DONE.
    // One finalize cycle in DONE raises done after the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_r       <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE && !done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else if (bus.start) begin
                        op_r       <= bus.op;
                        stim       <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        cnt        <= CNT_LOAD;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    err_count <= err_nxt;
                    if (mismatch && !fail_valid) begin
                        first_fail <= stim;
                        fail_valid <= 1'b1;
                    end
                    if (&stim) begin
                        pass  <= (err_nxt == '0);
                        state <= S_DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        cnt   <= CNT_LOAD;
                        state <= S_WAIT;
                    end
                end
            endcase
        end
    end

endmodule
